// File: rtl/xor_sched_pkg.sv
// Shared types and defaults for the XOR slice scheduler.
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_NUM_REQ    = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_LANES      = 4;

  // Number of slice passes needed to cover one operand.
  function automatic int unsigned beats(input int unsigned data_width,
                                        input int unsigned lanes);
    return data_width / lanes;
  endfunction

endpackage

// File: rtl/xor_slice_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_ptr,
// wrapping around. The pointer register lives in the scheduler.
module xor_slice_scheduler_rr_arbiter
  import xor_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  // One spare bit so ptr + offset can exceed NUM_REQ before the wrap.
  logic [IDW:0] w_pos;

  // Scan from the pointer upward and take the first pending request.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_pos >= (IDW+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDW+1)'(NUM_REQ);
      end
      if (!o_any && i_req[w_pos[IDW-1:0]]) begin
        o_any                     = 1'b1;
        o_grant[w_pos[IDW-1:0]]   = 1'b1;
        o_idx                     = w_pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/xor_slice_scheduler.sv
// Shares one external 4-lane XOR slice among NUM_REQ requesters, walking
// each operand through the slice one nibble per clock, LSB nibble first.
module xor_slice_scheduler
  import xor_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned LANES      = DEFAULT_LANES,
  localparam int unsigned BEATS      = beats(DATA_WIDTH, LANES),
  localparam int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_inv,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_zero,
  output logic                          busy,
  output logic [LANES-1:0]              slice_a,
  output logic [LANES-1:0]              slice_b,
  input  logic [LANES-1:0]              slice_y
);

  state_t                r_state;
  logic [IDW-1:0]        r_ptr;
  logic [BW-1:0]         r_beat;
  logic [IDW-1:0]        r_id;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]        r_rsp_id;
  logic                  r_rsp_zero;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDW-1:0]        w_gidx;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_result_next;

  xor_slice_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Accept strobe: only in IDLE, and forced low while reset is held so a
  // waiting requester never sees a grant during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == IDLE)) begin
      req_ready = w_grant;
    end
  end

  // Result register with the current beat's slice output merged in.
  always_comb begin
    w_result_next = r_result;
    w_result_next[r_beat*LANES +: LANES] = slice_y;
  end

  // Slice inputs carry the current nibble only while running.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    if (r_state == RUN) begin
      slice_a = r_a[r_beat*LANES +: LANES];
      slice_b = r_b[r_beat*LANES +: LANES];
    end
  end

  // Control FSM: accept in IDLE, one nibble per clock in RUN, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_beat     <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rsp_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a      <= req_a[w_gidx*DATA_WIDTH +: DATA_WIDTH];
            // NOT a is a XOR all-ones, so inversion reuses the XOR path.
            r_b      <= req_inv[w_gidx] ? '1 : req_b[w_gidx*DATA_WIDTH +: DATA_WIDTH];
            r_id     <= w_gidx;
            r_result <= '0;
            r_beat   <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_result <= w_result_next;
          if (r_beat == BW'(BEATS - 1)) begin
            r_beat     <= '0;
            r_rsp_data <= w_result_next;
            r_rsp_zero <= (w_result_next == '0);
            r_rsp_id   <= r_id;
            r_state    <= DONE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_ptr   <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_xor_slice_scheduler.sv
// Self-checking bench for xor_slice_scheduler with a quad-XOR slice model.
module tb_xor_slice_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int L  = 4;
  localparam int NB = DW / L;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_inv;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_zero;
  logic            busy;
  logic [L-1:0]    slice_a;
  logic [L-1:0]    slice_b;
  logic [L-1:0]    slice_y;

  logic [DW-1:0]   op_a [N];
  logic [DW-1:0]   op_b [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_slice_scheduler #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .LANES      (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_inv   (req_inv),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .busy      (busy),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_y   (slice_y)
  );

  // Quad 2-input XOR part: four independent gates, output follows inputs.
  always_comb begin
    for (int i = 0; i < L; i++) slice_y[i] = slice_a[i] ^ slice_b[i];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
    end
  end

  function automatic logic [N-1:0] bit_n(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic inv);
    return inv ? ~a : (a ^ b);
  endfunction

  function automatic logic [L-1:0] nib(input logic [DW-1:0] v, input int k);
    return L'(v >> (k * L));
  endfunction

  // Round-robin choice: first pending index at or after ptr, wrapping.
  function automatic int ref_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (((pend >> ((ptr + k) % N)) & N'(1)) != '0) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle_start;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    req_inv   = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    cycle_start;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_inv   = 4'b0101;
    for (int i = 0; i < N; i++) begin
      op_a[i] = DW'($urandom);
      op_b[i] = DW'($urandom);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_req_ready: got %b required 0000", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zero, busy, slice_a, slice_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b id=%0d d=%h z=%b busy=%b sa=%h sb=%h required all 0",
               rsp_valid, rsp_id, rsp_data, rsp_zero, busy, slice_a, slice_b);
    end
    req_valid = '0;
    cycle_start;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, req_ready} !== '0) begin
      errors++; $display("FAIL idle_no_req: got busy=%b ready=%b required 0", busy, req_ready);
    end
  endtask

  task automatic test_single_ops;
    int            t_idx [3] = '{0, 2, 1};
    logic [DW-1:0] t_a   [3] = '{16'h1234, 16'hA5A5, 16'hBEEF};
    logic [DW-1:0] t_b   [3] = '{16'h00FF, 16'h1111, 16'hBEEF};
    logic          t_inv [3] = '{1'b0, 1'b1, 1'b0};
    logic [DW-1:0] exp;
    logic [L-1:0]  exp_sb;
    int            idx;
    for (int t = 0; t < 3; t++) begin
      do_reset;
      idx       = t_idx[t];
      op_a[idx] = t_a[t];
      op_b[idx] = t_b[t];
      req_inv   = t_inv[t] ? bit_n(idx) : '0;
      req_valid = bit_n(idx);
      exp       = ref_result(t_a[t], t_b[t], t_inv[t]);
      @(negedge clk);
      checks++;
      if (req_ready !== bit_n(idx)) begin
        errors++; $display("FAIL op%0d_accept: got %b required %b", t, req_ready, bit_n(idx));
      end
      cycle_start;
      req_valid = '0;
      op_a[idx] = DW'($urandom);
      op_b[idx] = DW'($urandom);
      req_inv   = ~req_inv;
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        exp_sb = t_inv[t] ? '1 : nib(t_b[t], k);
        checks++;
        if (slice_a !== nib(t_a[t], k) || slice_b !== exp_sb) begin
          errors++;
          $display("FAIL op%0d_beat%0d: got a=%h b=%h required a=%h b=%h",
                   t, k, slice_a, slice_b, nib(t_a[t], k), exp_sb);
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL op%0d_run%0d_flags: got valid=%b busy=%b required 0 1", t, k, rsp_valid, busy);
        end
        cycle_start;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== 2'(idx) || rsp_zero !== (exp == '0)) begin
        errors++;
        $display("FAIL op%0d_rsp: got v=%b d=%h id=%0d z=%b required 1 %h %0d %b",
                 t, rsp_valid, rsp_data, rsp_id, rsp_zero, exp, idx, (exp == '0));
      end
      checks++;
      if (slice_a !== '0 || slice_b !== '0) begin
        errors++; $display("FAIL op%0d_slice_idle: got a=%h b=%h required 0", t, slice_a, slice_b);
      end
      cycle_start;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL op%0d_back_idle: got busy=%b valid=%b required 0 0", t, busy, rsp_valid);
      end
    end
  endtask

  task automatic test_round_robin;
    int            ngr;
    int            last_c;
    int            g;
    logic [1:0]    q_id [$];
    logic [DW-1:0] q_d  [$];
    logic [1:0]    e_id;
    logic [DW-1:0] e_d;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_inv   = N'($urandom);
    for (int i = 0; i < N; i++) begin
      op_a[i] = DW'($urandom);
      op_b[i] = DW'($urandom);
    end
    req_valid = '1;
    repeat (2) @(negedge clk);
    cycle_start;
    rst_n  = 1'b1;
    ngr    = 0;
    last_c = 0;
    for (int c = 0; c < 40; c++) begin
      g = -1;
      @(negedge clk);
      if (req_ready !== '0) begin
        g = ngr % N;
        checks++;
        if (req_ready !== bit_n(g)) begin
          errors++; $display("FAIL rr_grant%0d: got %b required %b", ngr, req_ready, bit_n(g));
        end
        if (ngr > 0) begin
          checks++;
          if (c - last_c != 6) begin
            errors++; $display("FAIL rr_spacing%0d: got %0d cycles required 6", ngr, c - last_c);
          end
        end
        q_id.push_back(2'(g));
        q_d.push_back(ref_result(op_a[g], op_b[g], req_inv[g]));
        last_c = c;
        ngr++;
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (q_id.size() == 0) begin
          errors++; $display("FAIL rr_spurious_rsp: got rsp with id=%0d required none", rsp_id);
        end else begin
          e_id = q_id.pop_front();
          e_d  = q_d.pop_front();
          if (rsp_id !== e_id || rsp_data !== e_d) begin
            errors++;
            $display("FAIL rr_rsp: got id=%0d d=%h required id=%0d d=%h", rsp_id, rsp_data, e_id, e_d);
          end
        end
      end
      cycle_start;
      if (g >= 0) begin
        op_a[g] = DW'($urandom);
        op_b[g] = DW'($urandom);
      end
    end
    checks++;
    if (ngr < 5) begin
      errors++; $display("FAIL rr_grant_count: got %0d grants required at least 5", ngr);
    end
    req_valid = '0;
  endtask

  task automatic test_stall;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    do_reset;
    op_a[1]   = DW'($urandom);
    op_b[1]   = DW'($urandom);
    e1        = op_a[1] ^ op_b[1];
    req_valid = bit_n(1);
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== bit_n(1)) begin
      errors++; $display("FAIL stall_accept: got %b required 0010", req_ready);
    end
    cycle_start;
    op_a[2]   = DW'($urandom);
    op_b[2]   = DW'($urandom);
    e2        = op_a[2] ^ op_b[2];
    req_valid = bit_n(2);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL stall_run_grant%0d: got %b required 0000", k, req_ready);
      end
      cycle_start;
    end
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e1 || rsp_id !== 2'd1 || busy !== 1'b1 || req_ready !== '0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b d=%h id=%0d busy=%b rdy=%b required 1 %h 1 1 0000",
                 s, rsp_valid, rsp_data, rsp_id, busy, req_ready, e1);
      end
      cycle_start;
      if (s == 4) rsp_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== bit_n(2)) begin
      errors++;
      $display("FAIL stall_release: got busy=%b v=%b rdy=%b required 0 0 0100", busy, rsp_valid, req_ready);
    end
    cycle_start;
    req_valid = '0;
    repeat (NB) cycle_start;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e2 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL stall_next_rsp: got v=%b d=%h id=%0d required 1 %h 2", rsp_valid, rsp_data, rsp_id, e2);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] e3;
    do_reset;
    op_a[3]   = DW'($urandom);
    op_b[3]   = DW'($urandom);
    e3        = op_a[3] ^ op_b[3];
    req_valid = bit_n(3);
    @(negedge clk);
    checks++;
    if (req_ready !== bit_n(3)) begin
      errors++; $display("FAIL mid_accept: got %b required 1000", req_ready);
    end
    cycle_start;
    @(negedge clk);
    cycle_start;
    @(negedge clk);
    cycle_start;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, busy, slice_a, slice_b} !== '0) begin
      errors++;
      $display("FAIL mid_reset_now: got rdy=%b v=%b id=%0d d=%h z=%b busy=%b sa=%h sb=%h required all 0",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, busy, slice_a, slice_b);
    end
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy} !== '0) begin
      errors++; $display("FAIL mid_reset_held: got rdy=%b v=%b busy=%b required 0", req_ready, rsp_valid, busy);
    end
    cycle_start;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== bit_n(3) || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_regrant: got rdy=%b v=%b required 1000 0", req_ready, rsp_valid);
    end
    cycle_start;
    req_valid = '0;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_early_rsp%0d: got v=%b required 0", k, rsp_valid);
      end
      cycle_start;
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e3 || rsp_id !== 2'd3) begin
      errors++;
      $display("FAIL mid_rsp: got v=%b d=%h id=%0d required 1 %h 3", rsp_valid, rsp_data, rsp_id, e3);
    end
  endtask

  // Random traffic against a timeline model: idle accept, NB beats, hold.
  task automatic test_random;
    logic [N-1:0]  pend;
    logic [N-1:0]  e_rdy;
    int            m_ptr;
    int            m_phase;
    int            m_cnt;
    int            m_g;
    int            p;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic [DW-1:0] m_res;
    do_reset;
    pend    = '0;
    m_ptr   = 0;
    m_phase = 0;
    m_cnt   = 0;
    m_g     = 0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((pend & bit_n(i)) != '0) begin
          if ($urandom_range(0, 9) == 0) pend = pend & ~bit_n(i);
        end else if ($urandom_range(0, 2) == 0) begin
          op_a[i] = DW'($urandom);
          op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : DW'($urandom);
          req_inv = (req_inv & ~bit_n(i)) | (($urandom_range(0, 3) == 0) ? bit_n(i) : '0);
          pend    = pend | bit_n(i);
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      p     = ref_pick(pend, m_ptr);
      e_rdy = (m_phase == 0 && p >= 0) ? bit_n(p) : '0;
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== (m_phase == 2) || busy !== (m_phase != 0)) begin
        errors++;
        $display("FAIL rnd_ctrl c%0d: got rdy=%b v=%b busy=%b required %b %b %b",
                 c, req_ready, rsp_valid, busy, e_rdy, (m_phase == 2), (m_phase != 0));
      end
      if (m_phase == 1) begin
        checks++;
        if (slice_a !== nib(m_a, m_cnt) || slice_b !== nib(m_b, m_cnt)) begin
          errors++;
          $display("FAIL rnd_slice c%0d: got a=%h b=%h required a=%h b=%h",
                   c, slice_a, slice_b, nib(m_a, m_cnt), nib(m_b, m_cnt));
        end
      end
      if (m_phase == 2) begin
        checks++;
        if (rsp_data !== m_res || rsp_id !== 2'(m_g) || rsp_zero !== (m_res == '0)) begin
          errors++;
          $display("FAIL rnd_rsp c%0d: got d=%h id=%0d z=%b required %h %0d %b",
                   c, rsp_data, rsp_id, rsp_zero, m_res, m_g, (m_res == '0));
        end
      end
      case (m_phase)
        0: if (p >= 0) begin
          m_g     = p;
          m_a     = op_a[p];
          m_b     = req_inv[p] ? '1 : op_b[p];
          m_res   = ref_result(op_a[p], op_b[p], req_inv[p]);
          pend    = pend & ~bit_n(p);
          m_cnt   = 0;
          m_phase = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == NB) m_phase = 2;
        end
        default: if (rsp_ready) begin
          m_ptr   = (m_g + 1) % N;
          m_phase = 0;
        end
      endcase
      cycle_start;
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_inv   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    test_reset;
    test_single_ops;
    test_round_robin;
    test_stall;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
